// File: rtl/spi_master_tx_pkg.sv
// Shared definitions for the SPI initiator and the responder it talks to:
// FSM state encoding, SPI mode constants and default sizing.
package spi_master_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    TAIL  = 3'd4
  } spiState_t;

  // Mode 0, MSB first; the responder is built against the same constants.
  localparam bit CPOL      = 1'b0;
  localparam bit CPHA      = 1'b0;
  localparam bit MSB_FIRST = 1'b1;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_CLK_DIV = 2;

endpackage

// File: rtl/spi_master_tx_if.sv
// Host handshake plus SPI pins of the initiator, bundled as one interface.
interface spi_master_tx_if
  import spi_master_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();
  logic             start;
  logic [WIDTH-1:0] txData;
  logic [WIDTH-1:0] rxData;
  logic             busy;
  logic             done;
  logic             sclk;
  logic             cs_n;
  logic             mosi;
  logic             miso;

  modport master (
    input  start, txData, miso,
    output rxData, busy, done, sclk, cs_n, mosi
  );

  modport slave (
    output start, txData, miso,
    input  rxData, busy, done, sclk, cs_n, mosi
  );
endinterface

// File: rtl/spi_master_tx_bit_timer.sv
// Half-period divider and bit counter; tells the FSM when a phase ends and
// whether the bit being clocked is the last one of the word.
module spi_bit_timer #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  input  logic bitStep,
  output logic phase_end,
  output logic last_bit
);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  logic [DW-1:0] divCnt;
  logic [BW-1:0] bitCnt;

  assign phase_end = run && (divCnt == DIV_LAST);
  assign last_bit  = (bitCnt == BIT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divCnt <= '0;
      bitCnt <= '0;
    end else begin
      if (clear || phase_end) divCnt <= '0;
      else if (run)           divCnt <= divCnt + 1'b1;

      if (clear)        bitCnt <= '0;
      else if (bitStep) bitCnt <= bitCnt + 1'b1;
    end
  end
endmodule

// File: rtl/spi_master_tx.sv
// Mode-0, MSB-first, full-duplex SPI initiator: one WIDTH-bit transfer per
// accepted start, received word returned with a one-cycle done pulse.
module spi_master_tx
  import spi_master_tx_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic            clk,
  input  logic            reset_n,
  spi_master_tx_if.master bus
);
  spiState_t        stateReg, stateNext;
  logic [WIDTH-1:0] txShiftReg, txShiftNext;
  logic [WIDTH-1:0] rxShiftReg, rxShiftNext;
  logic [WIDTH-1:0] rxDataReg, rxDataNext;
  logic             sclkReg, sclkNext;
  logic             csReg, csNext;
  logic             mosiReg, mosiNext;
  logic             busyReg, busyNext;
  logic             doneReg, doneNext;

  logic accept, phaseEnd, lastBit;

  assign accept = (stateReg == IDLE) && bus.start;

  spi_bit_timer #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (accept),
    .run      (stateReg != IDLE),
    .bitStep  ((stateReg == HIGH) && phaseEnd),
    .phase_end(phaseEnd),
    .last_bit (lastBit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateReg   <= IDLE;
      txShiftReg <= '0;
      rxShiftReg <= '0;
      rxDataReg  <= '0;
      sclkReg    <= CPOL;
      csReg      <= 1'b1;
      mosiReg    <= 1'b0;
      busyReg    <= 1'b0;
      doneReg    <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      txShiftReg <= txShiftNext;
      rxShiftReg <= rxShiftNext;
      rxDataReg  <= rxDataNext;
      sclkReg    <= sclkNext;
      csReg      <= csNext;
      mosiReg    <= mosiNext;
      busyReg    <= busyNext;
      doneReg    <= doneNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    txShiftNext = txShiftReg;
    rxShiftNext = rxShiftReg;
    rxDataNext  = rxDataReg;
    sclkNext    = sclkReg;
    csNext      = csReg;
    mosiNext    = mosiReg;
    busyNext    = busyReg;
    doneNext    = 1'b0;

    unique case (stateReg)
      IDLE: if (bus.start) begin
        stateNext   = SETUP;
        txShiftNext = bus.txData;
        csNext      = 1'b0;
        mosiNext    = bus.txData[WIDTH-1];
        busyNext    = 1'b1;
      end
      SETUP, LOW: if (phaseEnd) begin
        stateNext = HIGH;
        sclkNext  = 1'b1;
      end
      HIGH: if (phaseEnd) begin
        // miso is sampled just before the falling edge; mosi moves with it.
        rxShiftNext = {rxShiftReg[WIDTH-2:0], bus.miso};
        sclkNext    = 1'b0;
        if (lastBit) begin
          stateNext = TAIL;
        end else begin
          stateNext   = LOW;
          txShiftNext = {txShiftReg[WIDTH-2:0], 1'b0};
          mosiNext    = txShiftReg[WIDTH-2];
        end
      end
      TAIL: if (phaseEnd) begin
        stateNext  = IDLE;
        csNext     = 1'b1;
        mosiNext   = 1'b0;
        rxDataNext = rxShiftReg;
        doneNext   = 1'b1;
        busyNext   = 1'b0;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.rxData = rxDataReg;
  assign bus.busy   = busyReg;
  assign bus.done   = doneReg;
  assign bus.sclk   = sclkReg;
  assign bus.cs_n   = csReg;
  assign bus.mosi   = mosiReg;
endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- SPI initiator for the system: drives sclk, cs_n and mosi, and samples miso, toward the existing shift-register-based SPI responder.
- Host presents a WIDTH-bit word and pulses start; the block runs one full-duplex, MSB-first, mode-0 (CPOL=0, CPHA=0) transfer.
- It then returns the received word with a one-cycle done pulse.
- Sits between the host/test logic and the SPI pins.

Parameters:
- WIDTH, 8, bits per transfer (≥2).
- CLK_DIV, 2, clk cycles per sclk half-period (≥1).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin transfer; sampled only when busy=0.
- txData  input  WIDTH  word to send; captured on the accepting edge.
- rxData  output  WIDTH  last received word; updated only at done.
- busy  output  1  high from the accepting edge until done.
- done  output  1  one-cycle pulse at transfer end.
- sclk  output  1  SPI clock, idle low.
- cs_n  output  1  chip select, active low.
- mosi  output  1  serial data to responder.
- miso  input  1  serial data from responder.

Behaviour:
- Reset (async, reset_n=0):
  - sclk=0, cs_n=1, mosi=0, busy=0, done=0, rxData=0.
  - State IDLE; counters and shift registers cleared.
  - Applies immediately, including mid-transfer; no partial rxData update.
- States and transitions:
  - IDLE: start=1 at posedge → SETUP. On that edge: txShift←txData, cs_n←0, mosi←txData[WIDTH-1], busy←1, divCnt←0, bitCnt←0.
  - SETUP (sclk=0) lasts CLK_DIV cycles. Final edge → HIGH, sclk←1.
  - HIGH (sclk=1) lasts CLK_DIV cycles. Final edge: rxShift←{rxShift[WIDTH-2:0],miso}, sclk←0, bitCnt++. If bitCnt was WIDTH-1 → TAIL, else → LOW with txShift shifted left and mosi←next bit.
  - LOW (sclk=0) lasts CLK_DIV cycles. Final edge → HIGH, sclk←1.
  - TAIL (sclk=0, cs_n still 0) lasts CLK_DIV cycles. Final edge: cs_n←1, mosi←0, rxData←rxShift, done←1, busy←0 → IDLE.
- Timing:
  - done is asserted exactly (2·WIDTH+1)·CLK_DIV cycles after the accepting edge (WIDTH=8, CLK_DIV=2 → 34).
  - Exactly WIDTH sclk rising edges per transfer.
  - mosi changes only while sclk=0 and is stable across every rising sclk edge.
- done is high for exactly one cycle; busy falls on the same edge.
- Start handling:
  - start while busy=1 is ignored and not queued.
  - start=1 in the cycle done=1 is accepted (back-to-back). cs_n is then 1 for that one cycle only; sclk stays 0 throughout.
- txData changes after acceptance have no effect on the transfer in progress.
- divCnt width: $clog2(CLK_DIV)+1; wraps to 0 at each phase end. bitCnt width: $clog2(WIDTH)+1.

Decomposition:
- Shared package:
  - State encoding: IDLE, SETUP, HIGH, LOW, TAIL (3-bit).
  - SPI mode constants: CPOL=0, CPHA=0, MSB_FIRST=1, shared with the responder.
  - Default WIDTH/CLK_DIV.
- One sub-module, spi_bit_timer:
  - Holds the divider counter and bit counter.
  - Outputs phase_end and last_bit to the FSM.
- The FSM and shift registers stay in spi_master_tx.

Test Plan:
- Loopback (miso tied to mosi), WIDTH=8, CLK_DIV=2, txData=8'hA5 → exactly 8 sclk rises, done at cycle 34 after the accepting edge, rxData=8'hA5, cs_n=1 afterwards.
- Responder model shifting out 8'h3C on sclk falling edges, txData=8'hC3 → responder captures 8'hC3, rxData=8'h3C.
- Timing check, CLK_DIV=1, txData=8'h01 → done 17 cycles after accept; mosi=0 at rises 1–7 and 1 at rise 8; sclk high/low phases each 1 cycle.
- start pulsed at cycle 10 of a busy transfer with txData=8'hFF → ignored; rxData and mosi sequence match the original word; only one done pulse.
- Back-to-back: start held high through done, tx 8'h12 then 8'h34 (loopback) → two done pulses 35 cycles apart (CLK_DIV=2); rxData=8'h12 then 8'h34; cs_n high for exactly 1 cycle between transfers.
- reset_n driven low at sclk rise 4 of an 8'hA5 transfer → outputs immediately sclk=0, cs_n=1, mosi=0, busy=0, rxData=0; a subsequent 8'h5A loopback transfer completes correctly.
